// File: rtl/game_core_seq.sv
// game_core_seq: N-object bounce physics held in a register file.
// A frame_tick starts one MOVE pass (one object per cycle), then one COLL pass
// (one unordered pair per cycle), then a single DONE cycle.
// Optional feature macro: GAME_CORE_GRAVITY_EN adds GRAVITY to vely after
// friction whenever there is no Y wall bounce that frame.
// Handshake: frame_tick is a one-cycle request accepted only in IDLE; busy is
// high while the frame is being computed, and frame_done pulses for one cycle at
// the end. A tick that arrives while not IDLE is dropped and counted in overrun_cnt.
module game_core_seq #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BOX_W     = 48,
  parameter int BOX_H     = 32,
  parameter int N         = 4,
  parameter int FRIC      = 255,
  parameter int CD_FRAMES = 5,
  parameter int GRAVITY   = 8,
  parameter int IW        = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic [IW-1:0]     rd_idx,
  output logic [9:0]        rd_posx,
  output logic [8:0]        rd_posy,
  output logic signed [9:0] rd_velx,
  output logic signed [9:0] rd_vely,
  output logic [7:0]        rd_hits,
  output logic [2:0]        rd_color,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_COLL, S_DONE} state_t;

`ifdef GAME_CORE_GRAVITY_EN
  localparam int GRAV_ADD = GRAVITY;
`else
  // Gravity compiled out: the term is always zero.
  localparam int GRAV_ADD = GRAVITY * 0;
`endif

  state_t          state, state_n;
  logic [IW-1:0]   mi, mi_n, ci, ci_n, cj, cj_n;

  logic [9:0]        posx  [N];
  logic [8:0]        posy  [N];
  logic signed [9:0] velx  [N];
  logic signed [9:0] vely  [N];
  logic [7:0]        hits  [N];
  logic [2:0]        color [N];
  logic [3:0]        cd    [N];

  logic [9:0]        mv_px, mv_py10;
  logic signed [9:0] mv_vx, mv_vy;
  logic              hit;

  // Negation that maps -512 to +511 instead of wrapping.
  function automatic logic signed [9:0] sat_neg(input logic signed [9:0] v);
    return (v == 10'sh200) ? 10'sh1FF : -v;
  endfunction

  // One axis of the MOVE step: friction, move using pre-friction velocity, wall bounce.
  function automatic void axis_step(input logic [9:0] pos, input logic signed [9:0] v,
                                    input int box, input int screen, input int grav,
                                    output logic [9:0] np, output logic signed [9:0] nv);
    logic signed [17:0] prod;
    logic signed [9:0]  vf;
    int c, t;
    prod = {{8{v[9]}}, v} * 18'(FRIC);
    vf   = prod[17:8];
    c    = int'(pos) + int'(v >>> 8);
    if (c <= 0) begin
      np = '0;
      nv = sat_neg(vf >>> 1);
    end else if (c + box >= screen) begin
      np = 10'(screen - box);
      nv = sat_neg(vf >>> 1);
    end else begin
      np = 10'(c);
      t  = int'(vf) + grav;
      if (t > 511) t = 511;
      nv = 10'(t);
    end
  endfunction

  // FSM state and scan index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mi    <= '0;
      ci    <= '0;
      cj    <= '0;
    end else begin
      state <= state_n;
      mi    <= mi_n;
      ci    <= ci_n;
      cj    <= cj_n;
    end
  end

  // Next-state, scan indices and status outputs.
  always_comb begin
    state_n    = state;
    mi_n       = mi;
    ci_n       = ci;
    cj_n       = cj;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: if (frame_tick) begin
        state_n = S_MOVE;
        mi_n    = '0;
      end
      S_MOVE: begin
        busy = 1'b1;
        if (mi == IW'(N - 1)) begin
          state_n = S_COLL;
          ci_n    = '0;
          cj_n    = IW'(1);
        end else begin
          mi_n = mi + 1'b1;
        end
      end
      S_COLL: begin
        busy = 1'b1;
        if (cj == IW'(N - 1)) begin
          if (ci == IW'(N - 2)) begin
            state_n = S_DONE;
          end else begin
            ci_n = ci + 1'b1;
            cj_n = ci + IW'(2);
          end
        end else begin
          cj_n = cj + 1'b1;
        end
      end
      default: begin
        frame_done = 1'b1;
        state_n    = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // MOVE datapath for the object selected by mi.
  always_comb begin
    axis_step(posx[mi], velx[mi], BOX_W, SCREEN_W, 0, mv_px, mv_vx);
    axis_step({1'b0, posy[mi]}, vely[mi], BOX_H, SCREEN_H, GRAV_ADD, mv_py10, mv_vy);
  end

  // COLL datapath: box overlap of pair (ci, cj), gated by both cooldowns.
  always_comb begin : coll_chk
    int xi, xj, yi, yj;
    xi  = int'(posx[ci]);
    xj  = int'(posx[cj]);
    yi  = int'(posy[ci]);
    yj  = int'(posy[cj]);
    hit = !((xi + BOX_W < xj) || (xi > xj + BOX_W) ||
            (yi + BOX_H < yj) || (yi > yj + BOX_H)) &&
          (cd[ci] == 4'd0) && (cd[cj] == 4'd0);
  end

  // Object register file: reset layout, MOVE writes one object, COLL writes a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        posx[k]  <= 10'(32 + 128 * (k % 4));
        posy[k]  <= 9'(32 + 96 * (k / 4));
        velx[k]  <= (k % 2 == 0) ? 10'sd256 : -10'sd256;
        vely[k]  <= (k % 4 < 2) ? 10'sd128 : -10'sd128;
        hits[k]  <= '0;
        color[k] <= 3'(k % 8);
        cd[k]    <= '0;
      end
    end else if (state == S_MOVE) begin
      posx[mi] <= mv_px;
      posy[mi] <= mv_py10[8:0];
      velx[mi] <= mv_vx;
      vely[mi] <= mv_vy;
      cd[mi]   <= (cd[mi] != 4'd0) ? cd[mi] - 4'd1 : 4'd0;
    end else if (state == S_COLL && hit) begin
      velx[ci]  <= sat_neg(velx[ci]);
      vely[ci]  <= sat_neg(vely[ci]);
      velx[cj]  <= sat_neg(velx[cj]);
      vely[cj]  <= sat_neg(vely[cj]);
      hits[ci]  <= (hits[ci] == 8'hFF) ? 8'hFF : hits[ci] + 8'd1;
      hits[cj]  <= (hits[cj] == 8'hFF) ? 8'hFF : hits[cj] + 8'd1;
      color[ci] <= color[ci] + 3'd1;
      color[cj] <= color[cj] + 3'd1;
      cd[ci]    <= 4'(CD_FRAMES);
      cd[cj]    <= 4'(CD_FRAMES);
    end
  end

  // Registered random-access read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_posx  <= '0;
      rd_posy  <= '0;
      rd_velx  <= '0;
      rd_vely  <= '0;
      rd_hits  <= '0;
      rd_color <= '0;
    end else if (int'(rd_idx) < N) begin
      rd_posx  <= posx[rd_idx];
      rd_posy  <= posy[rd_idx];
      rd_velx  <= velx[rd_idx];
      rd_vely  <= vely[rd_idx];
      rd_hits  <= hits[rd_idx];
      rd_color <= color[rd_idx];
    end
  end

  // Count ticks that arrive while a frame is in flight (including DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (frame_tick && state != S_IDLE && overrun_cnt != 8'hFF) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_core_seq.sv
// tb_game_core_seq: drives frames into game_core_seq and compares every object
// read back against a behavioural physics model through an expected queue.
module tb_game_core_seq;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 50;
`ifdef GAME_CORE_GRAVITY_EN
  localparam int GRAV = 8;
`else
  localparam int GRAV = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_tick;
  logic [IW-1:0]     rd_idx;
  logic [9:0]        rd_posx;
  logic [8:0]        rd_posy;
  logic signed [9:0] rd_velx;
  logic signed [9:0] rd_vely;
  logic [7:0]        rd_hits;
  logic [2:0]        rd_color;
  logic              busy;
  logic              frame_done;
  logic [7:0]        overrun_cnt;
  logic [1:0]        dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] exp_q[$];

  int m_px[N], m_py[N], m_vx[N], m_vy[N], m_h[N], m_c[N], m_cd[N];
  int m_ovr;

  game_core_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .rd_idx(rd_idx),
    .rd_posx(rd_posx), .rd_posy(rd_posy), .rd_velx(rd_velx), .rd_vely(rd_vely),
    .rd_hits(rd_hits), .rd_color(rd_color), .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int m_neg(input int x);
    return (x == -512) ? 511 : -x;
  endfunction

  function automatic void m_axis(input int pos, input int v, input int box, input int scr,
                                 input int grav, output int np, output int nv);
    int vf, c;
    vf = (v * 255) >>> 8;
    c  = pos + (v >>> 8);
    if (c <= 0) begin
      np = 0; nv = m_neg(vf >>> 1);
    end else if (c + box >= scr) begin
      np = scr - box; nv = m_neg(vf >>> 1);
    end else begin
      np = c; nv = vf + grav;
      if (nv > 511) nv = 511;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_px[i] = 32 + 128 * (i % 4);
      m_py[i] = 32 + 96 * (i / 4);
      m_vx[i] = (i % 2 == 0) ? 256 : -256;
      m_vy[i] = (i % 4 < 2) ? 128 : -128;
      m_h[i]  = 0;
      m_c[i]  = i % 8;
      m_cd[i] = 0;
    end
  endtask

  task automatic model_frame();
    int px, vx, py, vy;
    for (int i = 0; i < N; i++) begin
      if (m_cd[i] > 0) m_cd[i]--;
      m_axis(m_px[i], m_vx[i], 48, 640, 0, px, vx);
      m_axis(m_py[i], m_vy[i], 32, 480, GRAV, py, vy);
      m_px[i] = px; m_vx[i] = vx; m_py[i] = py; m_vy[i] = vy;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (!(m_px[i] + 48 < m_px[j] || m_px[i] > m_px[j] + 48 ||
              m_py[i] + 32 < m_py[j] || m_py[i] > m_py[j] + 32) &&
            m_cd[i] == 0 && m_cd[j] == 0) begin
          m_vx[i] = m_neg(m_vx[i]); m_vy[i] = m_neg(m_vy[i]);
          m_vx[j] = m_neg(m_vx[j]); m_vy[j] = m_neg(m_vy[j]);
          if (m_h[i] < 255) m_h[i]++;
          if (m_h[j] < 255) m_h[j]++;
          m_c[i] = (m_c[i] + 1) % 8;
          m_c[j] = (m_c[j] + 1) % 8;
          m_cd[i] = 5; m_cd[j] = 5;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] m_pack(input int i);
    return {10'(m_px[i]), 9'(m_py[i]), 10'(m_vx[i]), 10'(m_vy[i]), 8'(m_h[i]), 3'(m_c[i])};
  endfunction

  // ---- driver tasks ----
  task automatic read_all();
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_idx = IW'(i);
      exp_q.push_back(m_pack(i));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("obj%0d", i),
            64'({rd_posx, rd_posy, rd_velx, rd_vely, rd_hits, rd_color}), 64'(e));
    end
  endtask

  // Run one frame; extra_at>0 pulses another tick that many cycles after the first.
  task automatic run_frame(input int extra_at);
    int k, busy_cycles;
    bit seen;
    k = 0; busy_cycles = 0; seen = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    while (!seen && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      frame_tick = (k == extra_at);
      if (frame_done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    check("done_latency", 64'(k), 64'(11));
    check("busy_at_done", 64'(busy), 64'(0));
    check("busy_cycles", 64'(busy_cycles), 64'(10));
    if (extra_at > 0 && m_ovr < 255) m_ovr++;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    check("done_pulse_width", 64'(frame_done), 64'(0));
    check("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
    model_frame();
    read_all();
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; rd_idx = '0; m_ovr = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_overrun", 64'(overrun_cnt), 64'(0));
    check("rst_rd_posx", 64'(rd_posx), 64'(0));
    rst_n = 1'b1;

    // Reset layout of object 1.
    @(negedge clk);
    rd_idx = 2'd1;
    @(posedge clk);
    #1;
    check("r1_posx", 64'(rd_posx), 64'(160));
    check("r1_posy", 64'(rd_posy), 64'(32));
    check("r1_velx", 64'(rd_velx), -256);
    check("r1_vely", 64'(rd_vely), 64'(128));
    check("r1_color", 64'(rd_color), 64'(1));
    check("r1_hits", 64'(rd_hits), 64'(0));

    model_reset();
    read_all();

    // First frame, then explicit spot check of object 0.
    run_frame(0);
    @(negedge clk);
    rd_idx = 2'd0;
    @(posedge clk);
    #1;
    check("f1_posx0", 64'(rd_posx), 64'(33));
    check("f1_velx0", 64'(rd_velx), 64'(255));
    check("f1_posy0", 64'(rd_posy), 64'(32));
    check("f1_vely0", 64'(rd_vely), 64'(127));

    // Dropped ticks: mid-frame and coincident with DONE.
    run_frame(3);
    run_frame(11);

    // Long run: Y wall bounces near frame 32, collisions and cooldown near 80.
    for (int f = 0; f < 110; f++) run_frame(($urandom_range(0, 9) == 0) ? $urandom_range(1, 11) : 0);

    // Reset asserted in cycle 6 of a frame.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    check("midrst_overrun", 64'(overrun_cnt), 64'(0));
    check("midrst_rd_velx", 64'(rd_velx), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_ovr = 0;
    model_reset();
    read_all();
    run_frame(0);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
